// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave bridge and its byte RAM.
package spi_pkg;

  localparam int FRAME_W = 10;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_ram.sv
// Single-port byte RAM driven by completed SPI frames; the opcode in the top
// two frame bits selects address load, data write, or data read.
module spi_ram
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_SIZE+1:0] din,
  input  logic                 rx_valid,
  output logic [ADDR_SIZE-1:0] dout,
  output logic                 tx_valid
);

  logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

  logic [ADDR_SIZE-1:0] wr_addr_q;
  logic [ADDR_SIZE-1:0] rd_addr_q;
  logic [ADDR_SIZE-1:0] dout_q;
  logic                 tx_valid_q;

  logic [1:0]           opcode;
  logic [ADDR_SIZE-1:0] payload;
  logic                 wr_in_range;
  logic                 rd_in_range;

  assign opcode      = din[ADDR_SIZE+1:ADDR_SIZE];
  assign payload     = din[ADDR_SIZE-1:0];
  assign wr_in_range = 32'(wr_addr_q) < 32'(MEM_DEPTH);
  assign rd_in_range = 32'(rd_addr_q) < 32'(MEM_DEPTH);

  // Contents survive reset; rx_valid is cleared asynchronously so a reset
  // pulse can never let a half-received frame reach the array.
  always_ff @(posedge clk) begin
    if (rx_valid && (opcode == OP_WR_DATA) && wr_in_range) begin
      mem[wr_addr_q] <= payload;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_addr_q  <= '0;
      rd_addr_q  <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= 1'b0;
      if (rx_valid) begin
        case (opcode)
          OP_WR_ADDR: wr_addr_q <= payload;
          OP_RD_ADDR: rd_addr_q <= payload;
          OP_RD_DATA: begin
            dout_q     <= rd_in_range ? mem[rd_addr_q] : '0;
            tx_valid_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign dout     = dout_q;
  assign tx_valid = tx_valid_q;

endmodule

// File: rtl/spi_wrapper.sv
// SPI slave bridge: frames MOSI into command frames for spi_ram and shifts
// read data back out on MISO, MSB first. Runs entirely on clk.
module spi_wrapper
  import spi_pkg::*;
#(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic SS_n,
  input  logic MOSI,
  output logic MISO
);

  localparam int FW = ADDR_SIZE + 2;
  localparam int CW = $clog2(FW + 1);
  localparam int TW = $clog2(ADDR_SIZE + 1);
  localparam logic [CW-1:0] RX_LAST = CW'(FW - 1);
  localparam logic [TW-1:0] TX_LAST = TW'(ADDR_SIZE);

  spi_state_e           state_q;
  logic [FW-1:0]        shift_q;
  logic [CW-1:0]        bit_cnt_q;
  logic                 frame_done_q;
  logic                 rx_valid_q;
  logic                 rd_flag_q;
  logic [ADDR_SIZE-1:0] tx_shift_q;
  logic [TW-1:0]        tx_cnt_q;
  logic                 tx_active_q;
  logic                 miso_q;

  logic [ADDR_SIZE-1:0] ram_dout;
  logic                 ram_tx_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      bit_cnt_q    <= '0;
      frame_done_q <= 1'b0;
      rx_valid_q   <= 1'b0;
      rd_flag_q    <= 1'b0;
      tx_shift_q   <= '0;
      tx_cnt_q     <= '0;
      tx_active_q  <= 1'b0;
      miso_q       <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (SS_n) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        frame_done_q <= 1'b0;
        tx_cnt_q     <= '0;
        tx_active_q  <= 1'b0;
        miso_q       <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            state_q      <= CHK_CMD;
            bit_cnt_q    <= '0;
            frame_done_q <= 1'b0;
          end
          CHK_CMD: begin
            if (!MOSI)         state_q <= WRITE;
            else if (rd_flag_q) state_q <= READ_DATA;
            else               state_q <= READ_ADD;
          end
          WRITE, READ_ADD, READ_DATA: begin
            // Exactly one frame per select; later MOSI bits are dropped.
            if (!frame_done_q) begin
              shift_q <= {shift_q[FW-2:0], MOSI};
              if (bit_cnt_q == RX_LAST) begin
                bit_cnt_q    <= '0;
                frame_done_q <= 1'b1;
                rx_valid_q   <= 1'b1;
                if (state_q == READ_ADD) rd_flag_q <= 1'b1;
              end else begin
                bit_cnt_q <= bit_cnt_q + 1'b1;
              end
            end
            if (state_q == READ_DATA) begin
              if (tx_active_q) begin
                if (tx_cnt_q == TX_LAST) begin
                  tx_active_q <= 1'b0;
                  tx_cnt_q    <= '0;
                  miso_q      <= 1'b0;
                  rd_flag_q   <= 1'b0;
                end else begin
                  miso_q     <= tx_shift_q[ADDR_SIZE-1];
                  tx_shift_q <= {tx_shift_q[ADDR_SIZE-2:0], 1'b0};
                  tx_cnt_q   <= tx_cnt_q + 1'b1;
                end
              end else if (ram_tx_valid) begin
                miso_q      <= ram_dout[ADDR_SIZE-1];
                tx_shift_q  <= {ram_dout[ADDR_SIZE-2:0], 1'b0};
                tx_cnt_q    <= TW'(1);
                tx_active_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  spi_ram #(
    .MEM_DEPTH(MEM_DEPTH),
    .ADDR_SIZE(ADDR_SIZE)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .din     (shift_q),
    .rx_valid(rx_valid_q),
    .dout    (ram_dout),
    .tx_valid(ram_tx_valid)
  );

  assign MISO = miso_q;

endmodule

// File: tb/tb_spi_wrapper.sv
// Bench for spi_wrapper: directed frame table, hand-written abort/reset
// sequences, and random frames scored against a frame-level memory model.
module tb_spi_wrapper;
  import spi_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic SS_n;
  logic MOSI;
  logic MISO;

  int checks   = 0;
  int failures = 0;

  spi_wrapper #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .SS_n (SS_n),
    .MOSI (MOSI),
    .MISO (MISO)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // Frame-level reference model
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_wr;
  logic [7:0] mdl_rd;
  bit         mdl_flag;
  logic [7:0] exp_q [$];

  typedef struct {
    logic       cmd;
    logic [9:0] fr;
    logic [7:0] exp_byte;
    bit         exp_flag;
  } vec_t;

  vec_t vecs [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_frame(input logic cmd, input logic [9:0] fr, output logic [7:0] exp_byte);
    int kind;  // 0 write, 1 read-address, 2 read-data
    kind = (cmd == 1'b0) ? 0 : (mdl_flag ? 2 : 1);
    exp_byte = 8'h00;
    case (fr[9:8])
      2'b00: mdl_wr = fr[7:0];
      2'b01: mdl_mem[mdl_wr] = fr[7:0];
      2'b10: mdl_rd = fr[7:0];
      default: begin
        if (kind == 2) begin
          exp_byte = mdl_mem[mdl_rd];
          mdl_flag = 1'b0;
        end
      end
    endcase
    if (kind == 1) mdl_flag = 1'b1;
  endtask

  // One select window: idle edge, command bit, 10 payload bits, then the
  // MISO window; noisy flags any 1 on MISO outside the 8 data bit slots.
  task automatic run_frame(input logic cmd, input logic [9:0] fr, input int hold,
                           output logic [7:0] got, output bit noisy);
    noisy = 1'b0;
    got   = 8'h00;
    @(negedge clk); SS_n = 1'b0; MOSI = 1'($urandom_range(0, 1));
    @(negedge clk); MOSI = cmd;
    for (int i = 9; i >= 0; i--) begin
      @(negedge clk); MOSI = fr[i];
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); MOSI = 1'($urandom_range(0, 1));
      if (MISO !== 1'b0) noisy = 1'b1;
    end
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk); MOSI = 1'($urandom_range(0, 1));
      got[i] = MISO;
    end
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk); MOSI = 1'($urandom_range(0, 1));
      if (MISO !== 1'b0) noisy = 1'b1;
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
  endtask

  task automatic check_frame(input string name, input logic cmd, input logic [9:0] fr,
                             input logic [7:0] exp_byte, input bit exp_flag, input int hold);
    logic [7:0] got;
    logic [7:0] mb;
    bit noisy;
    model_frame(cmd, fr, mb);
    run_frame(cmd, fr, hold, got, noisy);
    check({name, "_miso_byte"}, 32'(got), 32'(exp_byte));
    check({name, "_miso_quiet"}, 32'(noisy), 32'd0);
    check({name, "_rd_flag"}, 32'(dut.rd_flag_q), 32'(exp_flag));
  endtask

  task automatic random_frame(input logic cmd, input logic [9:0] fr);
    logic [7:0] got;
    logic [7:0] mb;
    logic [7:0] exp_byte;
    bit noisy;
    model_frame(cmd, fr, mb);
    exp_q.push_back(mb);
    run_frame(cmd, fr, 0, got, noisy);
    exp_byte = exp_q.pop_front();
    check("rand_miso_byte", 32'(got), 32'(exp_byte));
    check("rand_miso_quiet", 32'(noisy), 32'd0);
    check("rand_rd_flag", 32'(dut.rd_flag_q), 32'(mdl_flag));
  endtask

  initial begin
    bit         saw_rx;
    logic [1:0] op;
    logic [7:0] pl;
    logic       cmd;

    for (int i = 0; i < 256; i++) mdl_mem[i] = 8'h00;
    mdl_wr = 8'h00; mdl_rd = 8'h00; mdl_flag = 1'b0;

    vecs[0]  = '{1'b0, 10'b00_0000_0000, 8'h00, 1'b0};
    vecs[1]  = '{1'b0, 10'b01_0101_1010, 8'h00, 1'b0};
    vecs[2]  = '{1'b0, 10'b00_0000_1111, 8'h00, 1'b0};
    vecs[3]  = '{1'b0, 10'b01_1010_0101, 8'h00, 1'b0};
    vecs[4]  = '{1'b1, 10'b10_0000_1111, 8'h00, 1'b1};
    vecs[5]  = '{1'b1, 10'b11_0000_0000, 8'hA5, 1'b0};
    vecs[6]  = '{1'b0, 10'b00_0011_0000, 8'h00, 1'b0};
    vecs[7]  = '{1'b0, 10'b01_0011_1100, 8'h00, 1'b0};
    vecs[8]  = '{1'b1, 10'b10_0011_0000, 8'h00, 1'b1};
    vecs[9]  = '{1'b1, 10'b01_1111_1111, 8'h00, 1'b1};
    vecs[10] = '{1'b1, 10'b11_0000_0000, 8'hFF, 1'b0};
    vecs[11] = '{1'b0, 10'b11_0000_0000, 8'h00, 1'b0};
    vecs[12] = '{1'b1, 10'b10_0000_1111, 8'h00, 1'b1};
    vecs[13] = '{1'b1, 10'b11_1010_1010, 8'hA5, 1'b0};
    vecs[14] = '{1'b1, 10'b11_0000_0000, 8'h00, 1'b1};
    vecs[15] = '{1'b1, 10'b11_0000_0000, 8'hA5, 1'b0};

    // Reset then idle
    rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    @(negedge clk);
    check("reset_miso", 32'(MISO), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(IDLE));
    check("reset_rd_flag", 32'(dut.rd_flag_q), 32'd0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("idle_miso", 32'(MISO), 32'd0);
    check("idle_state", 32'(dut.state_q), 32'(IDLE));
    check("idle_rx_valid", 32'(dut.rx_valid_q), 32'd0);
    check("idle_tx_valid", 32'(dut.u_ram.tx_valid_q), 32'd0);

    for (int i = 0; i < 16; i++) begin
      check_frame($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].fr,
                  vecs[i].exp_byte, vecs[i].exp_flag, 0);
    end

    // Write-address load, then a write-data frame aborted after 5 bits
    check_frame("wr_addr_0f", 1'b0, 10'b00_0000_1111, 8'h00, 1'b0, 0);
    check("wr_addr_value", 32'(dut.u_ram.wr_addr_q), 32'h0F);
    saw_rx = 1'b0;
    @(negedge clk); SS_n = 1'b0;
    @(negedge clk); MOSI = 1'b0;
    for (int i = 9; i >= 5; i--) begin
      @(negedge clk); MOSI = vecs[1].fr[i];
      if (dut.rx_valid_q) saw_rx = 1'b1;
    end
    @(negedge clk); SS_n = 1'b1; MOSI = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (dut.rx_valid_q) saw_rx = 1'b1;
    end
    check("abort_no_rx_valid", 32'(saw_rx), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(IDLE));
    check_frame("abort_rd_addr", 1'b1, 10'b10_0000_1111, 8'h00, 1'b1, 0);
    check_frame("abort_rd_data", 1'b1, 10'b11_0000_0000, 8'hA5, 1'b0, 0);

    // Reset pulse in the middle of a read-address frame
    @(negedge clk); SS_n = 1'b0;
    @(negedge clk); MOSI = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); MOSI = 1'($urandom_range(0, 1));
    end
    @(negedge clk); rst_n = 1'b0;
    #1;
    check("midrst_state", 32'(dut.state_q), 32'(IDLE));
    check("midrst_rd_flag", 32'(dut.rd_flag_q), 32'd0);
    check("midrst_rd_addr", 32'(dut.u_ram.rd_addr_q), 32'd0);
    check("midrst_wr_addr", 32'(dut.u_ram.wr_addr_q), 32'd0);
    check("midrst_miso", 32'(MISO), 32'd0);
    @(negedge clk); rst_n = 1'b1; SS_n = 1'b1; MOSI = 1'b0;
    mdl_wr = 8'h00; mdl_rd = 8'h00; mdl_flag = 1'b0;

    check_frame("post_rst_rd_add", 1'b1, 10'b00_0000_0001, 8'h00, 1'b1, 0);
    check("post_rst_wr_addr", 32'(dut.u_ram.wr_addr_q), 32'h01);
    check_frame("post_rst_rd_data", 1'b1, 10'b11_0000_0000, 8'h5A, 1'b0, 6);

    // Randomized frames; addresses kept in 0..15 after initialising them
    for (int a = 0; a < 16; a++) begin
      random_frame(1'b0, {2'b00, 8'(a)});
      random_frame(1'b0, {2'b01, 8'($urandom_range(0, 255))});
    end
    for (int n = 0; n < 40; n++) begin
      op  = 2'($urandom_range(0, 3));
      pl  = (op == 2'b00 || op == 2'b10) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
      cmd = ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0;
      random_frame(cmd, {op, pl});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
